// File: rtl/csa_share_arbiter_if.sv
// Bundles requester, shared-adder and response signals of csa_share_arbiter.
// The arbiter connects through the slave modport; clients and the adder sit on the master side.
interface csa_share_arbiter_if #(
  parameter int WIDTH = 14,
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ*WIDTH-1:0] i_req_a;
  logic [N_REQ*WIDTH-1:0] i_req_b;
  logic [N_REQ-1:0]       o_req_ready;
  logic [WIDTH-1:0]       o_add_term1;
  logic [WIDTH-1:0]       o_add_term2;
  logic [WIDTH-1:0]       i_add_sum;
  logic                   i_add_cout;
  logic                   o_rsp_valid;
  logic [ID_W-1:0]        o_rsp_id;
  logic [WIDTH-1:0]       o_rsp_sum;
  logic                   o_rsp_cout;
  logic                   i_rsp_ready;
  logic                   o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_add_sum, i_add_cout, i_rsp_ready,
    output o_req_ready, o_add_term1, o_add_term2, o_rsp_valid, o_rsp_id,
           o_rsp_sum, o_rsp_cout, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_add_sum, i_add_cout, i_rsp_ready,
    input  o_req_ready, o_add_term1, o_add_term2, o_rsp_valid, o_rsp_id,
           o_rsp_sum, o_rsp_cout, o_busy
  );
endinterface

// File: rtl/csa_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among
// N_REQ requesters, treating the adder as a SETTLE_CYCLES multicycle path.
module csa_share_arbiter #(
   parameter int WIDTH         = 14,
   parameter int N_REQ         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   csa_share_arbiter_if.slave   bus
);
   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr, id_q, win, ptr_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              any_req, grant, settle_done;
   logic [WIDTH-1:0]  req_a [N_REQ];
   logic [WIDTH-1:0]  req_b [N_REQ];
   logic [WIDTH-1:0]  term1_q, term2_q, rsp_sum_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic              rsp_valid_q, rsp_cout_q;

   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         req_a[k] = bus.i_req_a[k*WIDTH +: WIDTH];
         req_b[k] = bus.i_req_b[k*WIDTH +: WIDTH];
      end
   end

   // Winner is the first valid index at or above rr_ptr, wrapping.
   always_comb begin : winner_search
      logic [ID_W-1:0] idx;
      // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
      win     = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
         if (!any_req && bus.i_req_valid[idx]) begin
            any_req = 1'b1;
            win     = idx;
         end
      end
   end

   assign ptr_nxt     = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
   assign grant       = (state == IDLE) && any_req && i_rst_n;
   assign settle_done = (cnt == '0);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant)           state_nxt = BUSY;
         BUSY:    if (settle_done)     state_nxt = RESP;
         RESP:    if (bus.i_rsp_ready) state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rr_ptr      <= '0;
         cnt         <= '0;
         id_q        <= '0;
         term1_q     <= '0;
         term2_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         if (grant) begin
            term1_q <= req_a[win];
            term2_q <= req_b[win];
            id_q    <= win;
            rr_ptr  <= ptr_nxt;
            cnt     <= CNT_W'(SETTLE_CYCLES - 1);
         end
         if (state == BUSY) begin
            if (!settle_done) begin
               cnt <= cnt - 1'b1;
            end else begin
               rsp_sum_q   <= bus.i_add_sum;
               rsp_cout_q  <= bus.i_add_cout;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
            end
         end
         if (state == RESP && bus.i_rsp_ready) rsp_valid_q <= 1'b0;
      end
   end

   assign bus.o_req_ready = grant ? (N_REQ'(1) << win) : '0;
   assign bus.o_add_term1 = term1_q;
   assign bus.o_add_term2 = term2_q;
   assign bus.o_rsp_valid = rsp_valid_q;
   assign bus.o_rsp_id    = rsp_id_q;
   assign bus.o_rsp_sum   = rsp_sum_q;
   assign bus.o_rsp_cout  = rsp_cout_q;
   assign bus.o_busy      = (state != IDLE);
endmodule

// File: doc/csa_share_arbiter.md
Name: csa_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational carry-select adder (WIDTH bits, with carry-out) among N_REQ requesters.
- Accepts one operand pair per transaction through a per-requester valid/ready handshake.
- Drives registered operands into the external adder and waits a programmable settle time, treating the adder as a multicycle path.
- Captures sum and carry-out, then returns them with the requester ID through a valid/ready response port.
- Sits between client blocks and a shared csa_<WIDTH>bit instance.

Parameters:
WIDTH, 14, operand/sum width of the shared adder
N_REQ, 4, number of requesters (2..8)
SETTLE_CYCLES, 1, cycles the adder is given after operands are registered (>=1)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_req_valid  input  N_REQ  per-requester request valid
i_req_a  input  N_REQ*WIDTH  operand A, requester k at [k*WIDTH +: WIDTH]
i_req_b  input  N_REQ*WIDTH  operand B, same packing
o_req_ready  output  N_REQ  one-hot grant/accept
o_add_term1  output  WIDTH  registered operand A to shared adder
o_add_term2  output  WIDTH  registered operand B to shared adder
i_add_sum  input  WIDTH  adder sum
i_add_cout  input  1  adder carry-out
o_rsp_valid  output  1  response valid
o_rsp_id  output  clog2(N_REQ)  requester index of response
o_rsp_sum  output  WIDTH  captured sum
o_rsp_cout  output  1  captured carry-out
i_rsp_ready  input  1  response consumer ready
o_busy  output  1  high in BUSY or RESP

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-low, on i_rst_n.
- Reset values, applied at the first rising edge with i_rst_n=0:
  - state=IDLE, rr_ptr=0, settle counter=0.
  - o_add_term1/2=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_sum=0, o_rsp_cout=0, o_busy=0.
  - o_req_ready=0 while i_rst_n=0.
- Reset mid-operation: any in-flight transaction is discarded with no response. The granted requester has already completed its handshake.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If no i_req_valid bit is set, stay in IDLE.
  - Otherwise pick winner w: first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - o_req_ready = one-hot(w), combinational, same cycle. o_req_ready is 0 in all other states.
  - At the clock edge: o_add_term1/2 <= operands of w; id <= w; rr_ptr <= (w+1) mod N_REQ; counter <= SETTLE_CYCLES-1; state <= BUSY.
- BUSY:
  - If counter != 0, decrement.
  - If counter == 0: o_rsp_sum <= i_add_sum, o_rsp_cout <= i_add_cout, o_rsp_id <= id, o_rsp_valid <= 1; state <= RESP.
- RESP:
  - Outputs are held stable while i_rsp_ready=0.
  - When i_rsp_ready=1: o_rsp_valid <= 0, state <= IDLE.
  - No grant is issued in the same cycle as the drain.
- Latency: handshake at edge T.
  - o_add_term valid from T+1.
  - Capture at edge T+SETTLE_CYCLES.
  - o_rsp_valid high from cycle T+SETTLE_CYCLES+1.
  - Minimum initiation interval is SETTLE_CYCLES+2 cycles.
- o_add_term1/2 hold their last operands after a transaction; they are not cleared.
- Arithmetic: sum and cout are taken verbatim from the adder (unsigned, modulo 2^WIDTH, carry-in 0). The block does no arithmetic itself.
- Requesters must hold valid and operands until ready. Dropping valid before a grant is permitted and causes no error.
- If rr_ptr points at a non-requesting index, the search continues upward and wraps. A single requester is granted back-to-back.

Test Plan:
1. Basic add, SETTLE_CYCLES=1, model adder = a+b: req0 valid, a=100, b=200 at cycle 0 -> o_req_ready=0001 at cycle 0; o_rsp_valid at cycle 2 with id=0, sum=300, cout=0.
2. Overflow: req1, a=16383, b=1 -> rsp sum=0, cout=1, id=1. Then a=16383, b=16383 -> sum=16382, cout=1.
3. Fairness: all four valid continuously, i_rsp_ready=1 -> grant order 0,1,2,3,0,1. Grants are exactly 3 cycles apart with SETTLE_CYCLES=1 and 5 apart with SETTLE_CYCLES=3.
4. Pointer rotation: after a grant to 2, req1 and req3 both valid -> 3 granted first, then 1.
5. Backpressure: i_rsp_ready=0 for 5 cycles during RESP -> o_rsp_* stable, o_req_ready=0, o_busy=1. Raise ready -> IDLE next cycle, next grant the following cycle.
6. Reset mid-BUSY (SETTLE_CYCLES=3): assert i_rst_n=0 one cycle after a grant -> no response ever. All outputs 0 after the edge; first grant after reset goes to lowest valid index.
